// File: rtl/io_bridge_pkg.sv
// Shared types and constants for the round-robin I/O bridge.
// Latency: n/a (types, constants and elaboration-time helpers only).
// Backpressure: n/a.
package io_bridge_pkg;

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_WAIT_ACK  = 2'd1,
        ST_WAIT_NACK = 2'd2,
        ST_POST_WAIT = 2'd3
    } state_e;

    localparam logic [31:0] DEF_WIN_BASE = 32'hFD00_0000;
    localparam logic [31:0] DEF_WIN_MASK = 32'hFFF0_0000;

    // Bits needed to hold a timeout count of 0..tmo (at least one bit).
    function automatic int tmo_width(input int tmo);
        int w;
        w = 1;
        while ((1 << w) <= tmo) w++;
        return w;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin arbiter: one-hot grant plus index, searching upward from last winner + 1.
// Latency: combinational grant; the pointer register updates on the accepting edge.
// Backpressure: the pointer only advances when adv_i accepts the current grant.
module rr_arbiter #(
    parameter int NPORT = 2,
    parameter int IW    = (NPORT > 1) ? $clog2(NPORT) : 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic [NPORT-1:0] req_i,
    input  logic             adv_i,
    output logic             gnt_vld_o,
    output logic [NPORT-1:0] gnt_o,
    output logic [IW-1:0]    gnt_idx_o
);

    logic [IW-1:0] ptr_q;

    // Search from ptr+1 with wrap; walking the distance downward lets the nearest requester win last.
    always_comb begin
        int j;
        j         = 0;
        gnt_vld_o = 1'b0;
        gnt_o     = '0;
        gnt_idx_o = '0;
        for (int k = NPORT; k >= 1; k--) begin
            j = int'(ptr_q) + k;
            if (j >= NPORT) j = j - NPORT;
            if (req_i[j]) begin
                gnt_vld_o = 1'b1;
                gnt_o     = '0;
                gnt_o[j]  = 1'b1;
                gnt_idx_o = IW'(j);
            end
        end
    end

    // Remember the winner so it becomes lowest priority next time; reset favours port 0.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr_q <= IW'(NPORT - 1);
        end else if (adv_i && gnt_vld_o) begin
            ptr_q <= gnt_idx_o;
        end
    end

endmodule

// File: rtl/io_bridge_rr.sv
// Registered I/O bridge: round-robin NPORT requesters onto one windowed master bus.
// Latency: request -> m_cyc_o 1 cycle; m_ack_i -> s_ack_o 1 cycle (posted writes ack with m_cyc_o).
// Backpressure: one transaction in flight; response held until the requester drops its strobe.
module io_bridge_rr
    import io_bridge_pkg::*;
#(
    parameter int            NPORT      = 2,
    parameter int            AW         = 32,
    parameter int            DW         = 32,
    parameter logic [AW-1:0] WIN_BASE   = AW'(DEF_WIN_BASE),
    parameter logic [AW-1:0] WIN_MASK   = AW'(DEF_WIN_MASK),
    parameter int            TMO_CYCLES = 255,
    parameter int            POST_WR    = 0
) (
    input  logic                      clk_i,
    input  logic                      rst_i,
    input  logic [NPORT-1:0]          s_cyc_i,
    input  logic [NPORT-1:0]          s_stb_i,
    input  logic [NPORT-1:0]          s_we_i,
    input  logic [NPORT*(DW/8)-1:0]   s_sel_i,
    input  logic [NPORT*AW-1:0]       s_adr_i,
    input  logic [NPORT*DW-1:0]       s_dat_i,
    output logic [NPORT-1:0]          s_ack_o,
    output logic [NPORT-1:0]          s_err_o,
    output logic [NPORT*DW-1:0]       s_dat_o,
    output logic                      m_cyc_o,
    output logic                      m_stb_o,
    output logic                      m_we_o,
    output logic [DW/8-1:0]           m_sel_o,
    output logic [AW-1:0]             m_adr_o,
    output logic [DW-1:0]             m_dat_o,
    input  logic                      m_ack_i,
    input  logic                      m_err_i,
    input  logic [DW-1:0]             m_dat_i,
    output logic                      wr_err_o
);

    localparam int            SW     = DW / 8;
    localparam int            IW     = (NPORT > 1) ? $clog2(NPORT) : 1;
    localparam int            CW     = tmo_width(TMO_CYCLES);
    localparam logic [AW-1:0] WIN_HI = WIN_BASE & WIN_MASK;

    state_e              state_q;
    logic [IW-1:0]       gidx_q;
    logic [CW-1:0]       tmo_cnt_q, tmo_cnt_d;
    logic                m_cyc_q, m_stb_q, m_we_q;
    logic [SW-1:0]       m_sel_q;
    logic [AW-1:0]       m_adr_q;
    logic [DW-1:0]       m_dat_q;
    logic [NPORT-1:0]    s_ack_q, s_err_q;
    logic [NPORT*DW-1:0] s_dat_q;
    logic [NPORT-1:0]    pack_q, pack_d;
    logic                wr_err_q;

    logic [NPORT-1:0]    in_win, elig;
    logic                gnt_vld;
    logic [NPORT-1:0]    gnt_oh;
    logic [IW-1:0]       gnt_idx;
    logic                arb_go, grant_go, post_grant;
    logic [AW-1:0]       g_adr;
    logic [SW-1:0]       g_sel;
    logic [DW-1:0]       g_dat;
    logic                g_we, g_cyc, g_stb;
    logic                tmo_hit;
    logic                rsp_err, rsp_ack, abort, tmo_err, post_done, post_err;

    // Window filter; a port whose posted ack is still showing is held off so one strobe is one transfer.
    always_comb begin
        in_win = '0;
        for (int i = 0; i < NPORT; i++) begin
            in_win[i] = ((s_adr_i[i*AW +: AW] & WIN_MASK) == WIN_BASE);
        end
        elig = s_cyc_i & s_stb_i & in_win & ~pack_q;
    end

    // No grant while the device is still driving a response from the previous transfer.
    assign arb_go = (state_q == ST_IDLE) && !m_ack_i && !m_err_i;

    rr_arbiter #(
        .NPORT (NPORT),
        .IW    (IW)
    ) u_arb (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .req_i     (elig),
        .adv_i     (arb_go),
        .gnt_vld_o (gnt_vld),
        .gnt_o     (gnt_oh),
        .gnt_idx_o (gnt_idx)
    );

    // Fields of the port being granted and of the port currently owning the bus.
    always_comb begin
        g_adr = s_adr_i[int'(gnt_idx)*AW +: AW];
        g_sel = s_sel_i[int'(gnt_idx)*SW +: SW];
        g_dat = s_dat_i[int'(gnt_idx)*DW +: DW];
        g_we  = s_we_i[gnt_idx];
        g_cyc = s_cyc_i[gidx_q];
        g_stb = s_stb_i[gidx_q];
    end

    // Decode of this cycle's FSM events; device error outranks ack, ack outranks abort and timeout.
    always_comb begin
        grant_go   = arb_go && gnt_vld;
        post_grant = grant_go && (POST_WR != 0) && g_we;
        tmo_cnt_d  = tmo_cnt_q + CW'(1);
        tmo_hit    = (TMO_CYCLES != 0) && (tmo_cnt_q == CW'(TMO_CYCLES - 1));
        rsp_err    = (state_q == ST_WAIT_ACK) && m_err_i;
        rsp_ack    = (state_q == ST_WAIT_ACK) && !m_err_i && m_ack_i;
        abort      = (state_q == ST_WAIT_ACK) && !m_err_i && !m_ack_i && !g_cyc;
        tmo_err    = (state_q == ST_WAIT_ACK) && !m_err_i && !m_ack_i && g_cyc && tmo_hit;
        post_done  = (state_q == ST_POST_WAIT) && (m_ack_i || m_err_i || tmo_hit);
        post_err   = (state_q == ST_POST_WAIT) && (m_err_i || tmo_hit);
    end

    // Main FSM with its registered master-bus and requester-response outputs.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q   <= ST_IDLE;
            gidx_q    <= '0;
            tmo_cnt_q <= '0;
            m_cyc_q   <= 1'b0;
            m_stb_q   <= 1'b0;
            m_we_q    <= 1'b0;
            m_sel_q   <= '0;
            m_adr_q   <= '1;
            m_dat_q   <= '0;
            s_ack_q   <= '0;
            s_err_q   <= '0;
            s_dat_q   <= '0;
            wr_err_q  <= 1'b0;
        end else begin
            wr_err_q <= post_err;

            if (grant_go) begin
                m_cyc_q <= 1'b1;
                m_stb_q <= 1'b1;
                m_we_q  <= g_we;
                m_sel_q <= g_sel;
                m_adr_q <= WIN_HI | (g_adr & ~WIN_MASK);
                m_dat_q <= g_dat;
            end else if ((state_q == ST_IDLE) || rsp_err || rsp_ack || abort || tmo_err || post_done) begin
                m_cyc_q <= 1'b0;
                m_stb_q <= 1'b0;
                m_we_q  <= 1'b0;
                m_sel_q <= '0;
                m_adr_q <= '1;
                m_dat_q <= '0;
            end

            case (state_q)
                ST_IDLE: begin
                    if (grant_go) begin
                        gidx_q    <= gnt_idx;
                        tmo_cnt_q <= '0;
                        state_q   <= post_grant ? ST_POST_WAIT : ST_WAIT_ACK;
                    end
                end
                ST_WAIT_ACK: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    if (rsp_err || tmo_err) begin
                        s_err_q[gidx_q]                   <= 1'b1;
                        s_dat_q[int'(gidx_q)*DW +: DW]    <= '0;
                        state_q                           <= ST_WAIT_NACK;
                    end else if (rsp_ack) begin
                        s_ack_q[gidx_q]                   <= 1'b1;
                        s_dat_q[int'(gidx_q)*DW +: DW]    <= m_dat_i;
                        state_q                           <= ST_WAIT_NACK;
                    end else if (abort) begin
                        state_q <= ST_IDLE;
                    end
                end
                ST_WAIT_NACK: begin
                    if (!(g_cyc && g_stb)) begin
                        s_ack_q <= '0;
                        s_err_q <= '0;
                        s_dat_q <= '0;
                        state_q <= ST_IDLE;
                    end
                end
                ST_POST_WAIT: begin
                    tmo_cnt_q <= tmo_cnt_d;
                    if (post_done) state_q <= ST_IDLE;
                end
                default: state_q <= ST_IDLE;
            endcase
        end
    end

    // Posted-write ack follows the requester's strobe, not the FSM.
    always_comb begin
        pack_d = (pack_q & s_stb_i) | (post_grant ? gnt_oh : '0);
    end

    // Posted-write ack register.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) pack_q <= '0;
        else       pack_q <= pack_d;
    end

    assign s_ack_o  = s_ack_q | pack_q;
    assign s_err_o  = s_err_q;
    assign s_dat_o  = s_dat_q;
    assign m_cyc_o  = m_cyc_q;
    assign m_stb_o  = m_stb_q;
    assign m_we_o   = m_we_q;
    assign m_sel_o  = m_sel_q;
    assign m_adr_o  = m_adr_q;
    assign m_dat_o  = m_dat_q;
    assign wr_err_o = wr_err_q;

endmodule

// File: tb/tb_io_bridge_rr.sv
// Directed bench for io_bridge_rr (3 ports, 8-cycle timeout, posted writes).
// Latency: n/a.
// Backpressure: the bench plays both requesters and the device.
module tb_io_bridge_rr;

    localparam int NP = 3;
    localparam int AW = 32;
    localparam int DW = 32;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [NP-1:0]     s_cyc = '0, s_stb = '0, s_we = '0;
    logic [NP*4-1:0]   s_sel = '0;
    logic [NP*AW-1:0]  s_adr = '0;
    logic [NP*DW-1:0]  s_wdat = '0;
    logic [NP-1:0]     s_ack, s_err;
    logic [NP*DW-1:0]  s_rdat;
    logic              m_cyc, m_stb, m_we;
    logic [3:0]        m_sel;
    logic [AW-1:0]     m_adr;
    logic [DW-1:0]     m_dat;
    logic              m_ack = 1'b0, m_err = 1'b0;
    logic [DW-1:0]     m_rdat = '0;
    logic              wr_err;

    int n_vec = 0;
    int n_mis = 0;
    logic [31:0] exp_q[$];

    always #5 clk = ~clk;

    io_bridge_rr #(
        .NPORT(NP), .AW(AW), .DW(DW),
        .WIN_BASE(32'hFD00_0000), .WIN_MASK(32'hFFF0_0000),
        .TMO_CYCLES(8), .POST_WR(1)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .s_cyc_i(s_cyc), .s_stb_i(s_stb), .s_we_i(s_we), .s_sel_i(s_sel),
        .s_adr_i(s_adr), .s_dat_i(s_wdat),
        .s_ack_o(s_ack), .s_err_o(s_err), .s_dat_o(s_rdat),
        .m_cyc_o(m_cyc), .m_stb_o(m_stb), .m_we_o(m_we), .m_sel_o(m_sel),
        .m_adr_o(m_adr), .m_dat_o(m_dat),
        .m_ack_i(m_ack), .m_err_i(m_err), .m_dat_i(m_rdat),
        .wr_err_o(wr_err)
    );

    task automatic chk(input string tag, input logic [95:0] obs, input logic [95:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_mis++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic req(input int p, input logic we, input logic [31:0] adr, input logic [31:0] dat);
        s_cyc[p]         = 1'b1;
        s_stb[p]         = 1'b1;
        s_we[p]          = we;
        s_sel[p*4 +: 4]  = 4'hF;
        s_adr[p*32 +: 32] = adr;
        s_wdat[p*32 +: 32] = dat;
    endtask

    task automatic drop(input int p);
        s_cyc[p] = 1'b0;
        s_stb[p] = 1'b0;
        s_we[p]  = 1'b0;
    endtask

    initial begin
        int g, n;
        logic bad;
        logic [31:0] ev;

        // ---- reset values
        #12;
        chk("rst_m_cyc", m_cyc, 0);
        chk("rst_m_stb", m_stb, 0);
        chk("rst_m_adr", m_adr, 32'hFFFF_FFFF);
        chk("rst_m_dat", m_dat, 0);
        chk("rst_m_sel", m_sel, 0);
        chk("rst_s_ack", s_ack, 0);
        chk("rst_s_err", s_err, 0);
        chk("rst_s_dat", s_rdat, 0);
        chk("rst_wr_err", wr_err, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // ---- round robin: three ports request continuously, expect 0,1,2,0
        for (int p = 0; p < NP; p++) req(p, 1'b0, 32'hFD00_0100 | (p << 4), 32'h0);
        exp_q.push_back(0); exp_q.push_back(1); exp_q.push_back(2); exp_q.push_back(0);
        for (int r = 0; r < 4; r++) begin
            tick();
            g = int'(exp_q.pop_front());
            chk("rr_cyc", m_cyc, 1);
            chk("rr_grant", m_adr[5:4], g);
            m_ack  = 1'b1;
            m_rdat = 32'hA000_0000 | r;
            tick();
            m_ack = 1'b0;
            chk("rr_ack", s_ack, 3'b001 << g);
            chk("rr_dat", s_rdat[g*32 +: 32], 32'hA000_0000 | r);
            s_stb[g] = 1'b0;
            tick();
            chk("rr_clr", s_ack, 0);
            if (r < 3) s_stb[g] = 1'b1;
            else for (int p = 0; p < NP; p++) drop(p);
        end
        tick();

        // ---- single read, device returns DEADBEEF
        req(0, 1'b0, 32'hFD00_0010, 32'h0);
        exp_q.push_back(32'hDEAD_BEEF);
        tick();
        chk("rd_cyc", m_cyc, 1);
        chk("rd_stb", m_stb, 1);
        chk("rd_adr", m_adr, 32'hFD00_0010);
        chk("rd_we", m_we, 0);
        tick();
        tick();
        chk("rd_noack", s_ack, 0);
        m_ack  = 1'b1;
        m_rdat = 32'hDEAD_BEEF;
        tick();
        m_ack = 1'b0;
        ev = exp_q.pop_front();
        chk("rd_ack", s_ack, 3'b001);
        chk("rd_dat", s_rdat[31:0], ev);
        chk("rd_other_dat", s_rdat[95:32], 0);
        chk("rd_bus_drop", m_cyc, 0);
        tick();
        chk("rd_hold", s_ack, 3'b001);
        drop(0);
        tick();
        chk("rd_clr_ack", s_ack, 0);
        chk("rd_clr_dat", s_rdat, 0);

        // ---- out-of-window request is ignored
        req(1, 1'b0, 32'hFE00_0000, 32'h0);
        bad = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (m_cyc || s_ack[1] || s_err[1] || (m_adr != 32'hFFFF_FFFF)) bad = 1'b1;
        end
        chk("oow_ignored", bad, 0);
        drop(1);
        tick();

        // ---- timeout with a silent device
        req(2, 1'b0, 32'hFD00_0020, 32'h0);
        tick();
        n   = 0;
        bad = 1'b0;
        while (m_cyc && n < 50) begin
            n++;
            if (s_ack != 0) bad = 1'b1;
            tick();
        end
        chk("tmo_cycles", n, 8);
        chk("tmo_err", s_err, 3'b100);
        chk("tmo_noack", {bad, s_ack}, 0);
        drop(2);
        tick();
        chk("tmo_err_clr", s_err, 0);

        // ---- device error wins over a simultaneous ack
        req(2, 1'b0, 32'hFD00_0024, 32'h0);
        tick();
        m_err  = 1'b1;
        m_ack  = 1'b1;
        m_rdat = 32'hFFFF_FFFF;
        tick();
        m_err = 1'b0;
        m_ack = 1'b0;
        chk("err_s_err", s_err, 3'b100);
        chk("err_s_ack", s_ack, 0);
        chk("err_s_dat", s_rdat, 0);
        drop(2);
        tick();

        // ---- posted write, second request stalls until device ack
        req(0, 1'b1, 32'hFD00_0004, 32'h0000_1234);
        tick();
        chk("pw_cyc", m_cyc, 1);
        chk("pw_we", m_we, 1);
        chk("pw_dat", m_dat, 32'h0000_1234);
        chk("pw_sel", m_sel, 4'hF);
        chk("pw_adr", m_adr, 32'hFD00_0004);
        chk("pw_early_ack", s_ack, 3'b001);
        drop(0);
        req(1, 1'b0, 32'hFD00_0030, 32'h0);
        tick();
        chk("pw_ack_clr", s_ack, 0);
        chk("pw_stall_adr", m_adr, 32'hFD00_0004);
        tick();
        tick();
        chk("pw_stall_cyc", {m_cyc, m_adr}, {1'b1, 32'hFD00_0004});
        m_ack = 1'b1;
        tick();
        m_ack = 1'b0;
        chk("pw_done_cyc", m_cyc, 0);
        chk("pw_done_wr_err", wr_err, 0);
        chk("pw_no_reack", s_ack, 0);
        tick();
        chk("pw_next_grant", {m_cyc, m_adr}, {1'b1, 32'hFD00_0030});
        m_ack  = 1'b1;
        m_rdat = 32'h0000_0055;
        tick();
        m_ack = 1'b0;
        chk("pw_next_ack", s_ack, 3'b010);
        chk("pw_next_dat", s_rdat[63:32], 32'h0000_0055);
        drop(1);
        tick();

        // ---- posted write ending in device error
        req(0, 1'b1, 32'hFD00_0008, 32'h0000_BEEF);
        tick();
        chk("pe_early_ack", s_ack, 3'b001);
        drop(0);
        tick();
        tick();
        m_err = 1'b1;
        tick();
        m_err = 1'b0;
        chk("pe_wr_err", wr_err, 1);
        chk("pe_no_s_err", s_err, 0);
        chk("pe_bus_drop", m_cyc, 0);
        tick();
        chk("pe_pulse_end", wr_err, 0);

        // ---- requester abort in WAIT_ACK
        req(1, 1'b0, 32'hFD00_0040, 32'h0);
        tick();
        chk("ab_cyc", m_cyc, 1);
        drop(1);
        tick();
        chk("ab_drop", m_cyc, 0);
        bad = 1'b0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if ((s_ack != 0) || (s_err != 0) || m_cyc) bad = 1'b1;
        end
        chk("ab_noresp", bad, 0);

        // ---- reset mid-read takes effect without a clock edge
        req(0, 1'b0, 32'hFD00_0050, 32'h0);
        tick();
        chk("mr_cyc", m_cyc, 1);
        #2;
        rst = 1'b1;
        #1;
        chk("mr_async_cyc", m_cyc, 0);
        chk("mr_async_adr", m_adr, 32'hFFFF_FFFF);
        chk("mr_async_ack", s_ack, 0);
        drop(0);
        tick();
        rst = 1'b0;
        tick();
        chk("mr_after", {m_cyc, s_ack, s_err}, 0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
        $finish;
    end

endmodule

// File: doc/io_bridge_rr.md
Name: io_bridge_rr

Overview:
- Parametrised successor to the single-master I/O bridge. It registers the I/O path and filters requests to one I/O address window.
- It arbitrates NPORT Wishbone-style requesters round-robin onto one master bus that feeds the I/O devices.
- New relative to the fixed two-port bridge: configurable width, port count and window, bus-error and timeout responses, and optional posted writes.
- Sits between the CPU/DMA-side interconnect and the low-speed peripheral bus.

Parameters:
- NPORT, 2, number of requester (slave-side) ports, 1..8.
- AW, 32, address width.
- DW, 32, data width; sel width is DW/8.
- WIN_BASE, 32'hFD00_0000, I/O window base.
- WIN_MASK, 32'hFFF0_0000, window compare mask. A request is in-window when (adr & WIN_MASK) == WIN_BASE.
- TMO_CYCLES, 255, master no-response timeout in cycles; 0 disables the timeout.
- POST_WR, 0, when 1, writes are acked to the requester before the device responds.

Ports:
- clk_i  in  1  clock.
- rst_i  in  1  reset, asynchronous, active-high.
- s_cyc_i  in  NPORT  per-port cycle.
- s_stb_i  in  NPORT  per-port strobe.
- s_we_i  in  NPORT  per-port write enable.
- s_sel_i  in  NPORT*DW/8  per-port byte selects, packed, port 0 in the LSBs.
- s_adr_i  in  NPORT*AW  per-port addresses, packed.
- s_dat_i  in  NPORT*DW  per-port write data, packed.
- s_ack_o  out  NPORT  per-port ack.
- s_err_o  out  NPORT  per-port bus error.
- s_dat_o  out  NPORT*DW  per-port read data.
- m_cyc_o, m_stb_o, m_we_o  out  1 each  master bus cycle, strobe and write enable.
- m_sel_o  out  DW/8  master byte selects.
- m_adr_o  out  AW  master address.
- m_dat_o  out  DW  master write data.
- m_ack_i  in  1  device ack.
- m_err_i  in  1  device error.
- m_dat_i  in  DW  device read data.
- wr_err_o  out  1  one-cycle pulse: a posted write ended in error or timeout.

Behaviour:
- Reset values (all registers asynchronously cleared by rst_i):
  - m_cyc_o, m_stb_o, m_we_o, m_sel_o, m_dat_o, s_ack_o, s_err_o, s_dat_o and wr_err_o = 0.
  - m_adr_o = all ones.
  - State = IDLE; round-robin pointer = NPORT-1, so port 0 has first priority.
- Requester eligibility: s_cyc_i[i] & s_stb_i[i] & in-window. Out-of-window requests are ignored and never acked.
- States: IDLE, WAIT_ACK, WAIT_NACK, POST_WAIT.
- IDLE:
  - No grant while m_ack_i or m_err_i is high.
  - Otherwise, grant the first eligible port searching upward from ptr+1, with wrap-around, then set ptr = grant.
  - Next cycle: m_cyc_o = m_stb_o = 1, and m_we_o/m_sel_o/m_dat_o copy the granted port.
  - m_adr_o = (WIN_BASE & WIN_MASK) | (adr & ~WIN_MASK), so the upper bits are constant.
  - With no grant, bus outputs hold their idle values (m_dat_o = 0, m_adr_o = all ones).
- WAIT_ACK:
  - Timeout counter clears on grant and increments each cycle.
  - m_ack_i: latch m_dat_i into the granted port's s_dat_o, assert its s_ack_o the next cycle, go to WAIT_NACK.
  - m_err_i: same, but assert s_err_o; s_dat_o = 0. m_err_i has priority over m_ack_i when both are high.
  - Counter reaches TMO_CYCLES (nonzero): drop m_cyc_o/m_stb_o/m_we_o, assert s_err_o, go to WAIT_NACK.
  - Granted port drops s_cyc_i (abort): drop the master bus next cycle, go to IDLE, no ack or err. An abort in the same cycle as m_ack_i takes the ack path; WAIT_NACK then clears it immediately.
- WAIT_NACK:
  - Master bus is deasserted on entry.
  - When the granted s_stb_i goes low: clear s_ack_o, s_err_o and s_dat_o the next cycle, go to IDLE.
  - ack/err for one transfer is therefore held until the strobe drops.
- POST_WR=1, write granted:
  - s_ack_o asserts in the same cycle as m_cyc_o (one cycle after grant).
  - It clears one cycle after the requester drops s_stb_i, independently of the state machine; the requester's s_ack_o never re-asserts for this transfer.
  - State goes to POST_WAIT, which holds the master bus until m_ack_i, m_err_i or timeout, then drops it and returns to IDLE. No new grant occurs before then.
  - Error or timeout pulses wr_err_o for one cycle; s_err_o is never asserted for posted writes.
- Reads are never posted.
- Latency: eligible request at cycle N → m_cyc_o at N+1. m_ack_i at cycle K → s_ack_o at K+1.
- Only one outstanding transaction at a time; non-granted ports see ack, err and dat at 0.
- rst_i mid-transaction: immediate return to reset values; no ack is produced.

Decomposition:
- Package io_bridge_pkg: state enum (IDLE, WAIT_ACK, WAIT_NACK, POST_WAIT), default window constants, timeout-width function.
- Sub-module rr_arbiter (NPORT): request vector in, pointer register, one-hot grant plus encoded index out, advance on accept.

Test Plan:
- Port 0 reads 32'hFD00_0010; device acks 3 cycles later with 32'hDEAD_BEEF → m_cyc_o one cycle after request; s_ack_o[0] one cycle after m_ack_i with s_dat_o[0] = DEADBEEF; both clear one cycle after s_stb_i[0] drops.
- Ports 0,1,2 request continuously (NPORT=3) → grants cycle 0,1,2,0; no port granted twice consecutively while others wait.
- Port 1 accesses 32'hFE00_0000 → m_cyc_o stays 0; no ack within 20 cycles.
- TMO_CYCLES=8, device silent → master bus dropped and s_err_o asserted after 8 WAIT_ACK cycles; s_ack_o never asserted.
- POST_WR=1, write 32'h1234 to FD00_0004 with device acking after 5 cycles → s_ack_o alongside m_cyc_o; second request stalls until m_ack_i. With m_err_i instead → wr_err_o one-cycle pulse.
- Requester aborts (s_cyc_i low) in WAIT_ACK, and rst_i asserted mid-read → m_cyc_o low the next cycle with no ack; reset returns outputs to reset values asynchronously.
